// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
// Holds opcode constants, FSM state encodings, the ALUOp class codes
// (also consumed by the ALU control stage) and the datapath mux select codes.
package mips_ctrl_pkg;

    // Instruction opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation classes handed to the ALU control stage
    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_SUB   = 4'b0001;
    localparam logic [3:0] ALUOP_FUNCT = 4'b0010;
    localparam logic [3:0] ALUOP_AND   = 4'b0011;
    localparam logic [3:0] ALUOP_OR    = 4'b0100;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_EXT    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM states; encodings 14 and 15 are unreachable
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTYPEEX = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BEQEX   = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ANDIEX  = 4'd10,
        ST_ORIEX   = 4'd11,
        ST_IMMWB   = 4'd12,
        ST_JEX     = 4'd13
    } state_e;

    // True for every opcode this control unit knows how to sequence
    function automatic logic is_known_op(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: known = 1'b1;
            default:                        known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-outputs decoder for the multicycle MIPS control FSM.
// Ports:
//   rst       - synchronous reset; while high every output is forced to 0
//   state     - current FSM state register
//   MemReady  - memory handshake; only qualifies IRWrite/PCWrite in FETCH
//   remaining - datapath enables, mux selects and ALUOp (see top header)
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               rst,
    input  logic [3:0]         state,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtZero,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp
);

    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       i_or_d_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       mem_to_reg_s;
    logic       reg_dst_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       ext_zero_s;
    logic [1:0] pc_source_s;
    logic [3:0] alu_op_s;

    // Decode the datapath controls for the current state
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        i_or_d_s        = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = SRCB_REGB;
        ext_zero_s      = 1'b0;
        pc_source_s     = PCSRC_ALU;
        alu_op_s        = ALUOP_ADD;
        case (state)
            ST_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                // IR and PC load only on the cycle the fetch actually completes
                ir_write_s  = MemReady;
                pc_write_s  = MemReady;
            end
            ST_DECODE: begin
                alu_src_b_s = SRCB_BRANCH;
            end
            ST_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_EXT;
            end
            ST_MEMRD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
            end
            ST_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            ST_MEMWR: begin
                mem_write_s = 1'b1;
                i_or_d_s    = 1'b1;
            end
            ST_RTYPEEX: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALUOP_FUNCT;
            end
            ST_RTYPEWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            ST_BEQEX: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = ALUOP_SUB;
                pc_write_cond_s = 1'b1;
                pc_source_s     = PCSRC_ALUOUT;
            end
            ST_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_EXT;
            end
            ST_ANDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_EXT;
                ext_zero_s  = 1'b1;
                alu_op_s    = ALUOP_AND;
            end
            ST_ORIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_EXT;
                ext_zero_s  = 1'b1;
                alu_op_s    = ALUOP_OR;
            end
            ST_IMMWB: begin
                reg_write_s = 1'b1;
            end
            ST_JEX: begin
                pc_write_s  = 1'b1;
                pc_source_s = PCSRC_JUMP;
            end
            default: begin
                // unreachable encodings keep every control inactive
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Reset gates the outputs immediately so no write can leak through
    assign PCWrite     = ~rst & pc_write_s;
    assign PCWriteCond = ~rst & pc_write_cond_s;
    assign IorD        = ~rst & i_or_d_s;
    assign MemRead     = ~rst & mem_read_s;
    assign MemWrite    = ~rst & mem_write_s;
    assign IRWrite     = ~rst & ir_write_s;
    assign MemtoReg    = ~rst & mem_to_reg_s;
    assign RegDst      = ~rst & reg_dst_s;
    assign RegWrite    = ~rst & reg_write_s;
    assign ALUSrcA     = ~rst & alu_src_a_s;
    assign ALUSrcB     = rst ? 2'b00 : alu_src_b_s;
    assign ExtZero     = ~rst & ext_zero_s;
    assign PCSource    = rst ? 2'b00 : pc_source_s;
    assign ALUOp       = rst ? '0 : ALUOP_W'(alu_op_s);

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS CPU.
// Sequences fetch / decode / execute / memory / writeback and drives the
// datapath enables, mux selects and the ALUOp class for the ALU control stage.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   Op                - instruction opcode IR[31:26], valid from DECODE onward
//   MemReady          - memory finished the current access this cycle
//   PCWrite..ALUOp    - datapath controls (Moore, except IRWrite/PCWrite in FETCH)
//   IllegalOp         - sticky flag set when an unknown opcode is decoded
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtZero,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               IllegalOp
);

    state_e state_r;
    state_e next_state_s;
    logic   illegal_r;
    logic   set_illegal_s;

    assign set_illegal_s = (state_r == ST_DECODE) && !is_known_op(Op);

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            illegal_r <= illegal_r | set_illegal_s;
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH:   next_state_s = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (Op)
                    OP_LW,
                    OP_SW:    next_state_s = ST_MEMADR;
                    OP_RTYPE: next_state_s = ST_RTYPEEX;
                    OP_BEQ:   next_state_s = ST_BEQEX;
                    OP_ADDI:  next_state_s = ST_ADDIEX;
                    OP_ANDI:  next_state_s = ST_ANDIEX;
                    OP_ORI:   next_state_s = ST_ORIEX;
                    OP_J:     next_state_s = ST_JEX;
                    default:  next_state_s = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                // Op is stable here; anything other than lw/sw falls back to FETCH
                case (Op)
                    OP_LW:   next_state_s = ST_MEMRD;
                    OP_SW:   next_state_s = ST_MEMWR;
                    default: next_state_s = ST_FETCH;
                endcase
            end
            ST_MEMRD:   next_state_s = MemReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:   next_state_s = ST_FETCH;
            ST_MEMWR:   next_state_s = MemReady ? ST_FETCH : ST_MEMWR;
            ST_RTYPEEX: next_state_s = ST_RTYPEWB;
            ST_RTYPEWB: next_state_s = ST_FETCH;
            ST_BEQEX:   next_state_s = ST_FETCH;
            ST_ADDIEX:  next_state_s = ST_IMMWB;
            ST_ANDIEX:  next_state_s = ST_IMMWB;
            ST_ORIEX:   next_state_s = ST_IMMWB;
            ST_IMMWB:   next_state_s = ST_FETCH;
            ST_JEX:     next_state_s = ST_FETCH;
            default:    next_state_s = ST_FETCH;
        endcase
    end

    // Output decode from the state register
    mips_ctrl_outdec #(
        .ALUOP_W (ALUOP_W)
    ) u_outdec (
        .rst         (rst),
        .state       (state_r),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ExtZero     (ExtZero),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp)
    );

    assign IllegalOp = ~rst & illegal_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control.
// A reference model expands each instruction into its list of control steps,
// inserts memory wait cycles, and predicts every output on every cycle.
module tb_mips_multicycle_control;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ANDI = 6'b001100;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_J    = 6'b000010;

    // step identifiers of the reference model
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
    localparam int P_RX = 6, P_RWB = 7, P_BQ = 8, P_AI = 9, P_AN = 10;
    localparam int P_OR = 11, P_IWB = 12, P_J = 13;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb;
        logic       extz;
        logic [1:0] pcs;
        logic [3:0] aluop;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'b000000;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ExtZero, IllegalOp;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp;

    ctl_t obs;
    int   n_vec = 0;
    int   n_bad = 0;
    logic ill_model = 1'b0;
    int   prog[$];

    logic [5:0] legal_ops [0:7] = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_ANDI, T_ORI, T_J};

    mips_multicycle_control #(.ALUOP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .Op          (Op),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ExtZero     (ExtZero),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .IllegalOp   (IllegalOp)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtZero, PCSource, ALUOp, IllegalOp};

    task automatic check_ctl(input string tag, input ctl_t got, input ctl_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Control values the specification lists for each step
    function automatic ctl_t expect_of(input int p, input logic rdy, input logic ill);
        ctl_t e;
        e = '0;
        e.ill = ill;
        case (p)
            P_F:   begin e.mrd = 1'b1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            P_D:   e.srcb = 2'b11;
            P_MA:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            P_MR:  begin e.mrd = 1'b1; e.iord = 1'b1; end
            P_MWB: begin e.rw = 1'b1; e.m2r = 1'b1; end
            P_MW:  begin e.mwr = 1'b1; e.iord = 1'b1; end
            P_RX:  begin e.srca = 1'b1; e.aluop = 4'b0010; end
            P_RWB: begin e.rw = 1'b1; e.rdst = 1'b1; end
            P_BQ:  begin e.srca = 1'b1; e.aluop = 4'b0001; e.pcwc = 1'b1; e.pcs = 2'b01; end
            P_AI:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            P_AN:  begin e.srca = 1'b1; e.srcb = 2'b10; e.extz = 1'b1; e.aluop = 4'b0011; end
            P_OR:  begin e.srca = 1'b1; e.srcb = 2'b10; e.extz = 1'b1; e.aluop = 4'b0100; end
            P_IWB: e.rw = 1'b1;
            P_J:   begin e.pcw = 1'b1; e.pcs = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Instruction -> ordered list of steps; unknown opcodes stop after decode
    task automatic build(input logic [5:0] op);
        case (op)
            T_LW:   prog = '{P_F, P_D, P_MA, P_MR, P_MWB};
            T_SW:   prog = '{P_F, P_D, P_MA, P_MW};
            T_R:    prog = '{P_F, P_D, P_RX, P_RWB};
            T_BEQ:  prog = '{P_F, P_D, P_BQ};
            T_ADDI: prog = '{P_F, P_D, P_AI, P_IWB};
            T_ANDI: prog = '{P_F, P_D, P_AN, P_IWB};
            T_ORI:  prog = '{P_F, P_D, P_OR, P_IWB};
            T_J:    prog = '{P_F, P_D, P_J};
            default: prog = '{P_F, P_D};
        endcase
    endtask

    // Each cycle starts at a falling edge: drive, settle, compare, wait.
    // fixed_wait < 0 picks random wait counts; stop_step >= 0 abandons the
    // instruction while still waiting in that step (used before a reset).
    task automatic run_instr(input logic [5:0] op, input int fixed_wait, input int stop_step);
        build(op);
        for (int i = 0; i < prog.size(); i++) begin
            int p;
            bit waitable;
            int w;
            p = prog[i];
            waitable = (p == P_F) || (p == P_MR) || (p == P_MW);
            w = waitable ? ((fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2))) : 0;
            for (int c = 0; c <= w; c++) begin
                if (i == stop_step && c == w) return;
                Op = op;
                MemReady = waitable ? (c == w) : 1'($urandom_range(0, 1));
                #1;
                check_ctl($sformatf("op=%b step=%0d cyc=%0d", op, i, c), obs,
                          expect_of(p, MemReady, ill_model));
                @(negedge clk);
            end
            if (p == P_D && prog.size() == 2) ill_model = 1'b1;
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            MemReady = 1'($urandom_range(0, 1));
            #1;
            check_ctl($sformatf("reset cyc=%0d", k), obs, ctl_t'(0));
            @(negedge clk);
        end
        rst = 1'b0;
        ill_model = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);

        // directed: one of each class with memory always ready
        run_instr(T_LW, 0, -1);
        run_instr(T_R, 0, -1);
        run_instr(T_ANDI, 0, -1);
        run_instr(T_ORI, 0, -1);
        run_instr(T_ADDI, 0, -1);
        run_instr(T_BEQ, 0, -1);
        run_instr(T_J, 0, -1);
        run_instr(T_SW, 0, -1);

        // three wait cycles in FETCH and in MEMRD
        run_instr(T_LW, 3, -1);
        run_instr(T_SW, 3, -1);

        // illegal opcode, flag must persist through following instructions
        run_instr(6'b111111, 0, -1);
        run_instr(T_LW, 1, -1);
        run_instr(T_R, 0, -1);

        // reset while a store is waiting for memory
        run_instr(T_SW, 2, 3);
        do_reset(2);
        run_instr(T_R, 0, -1);

        // randomized instruction stream with random memory latency
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int r;
            r = int'($urandom_range(0, 9));
            op = (r < 8) ? legal_ops[r] : 6'($urandom);
            run_instr(op, -1, -1);
            if (n == 120) begin
                run_instr(T_LW, 2, 3);
                do_reset(1 + int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM of the multicycle MIPS CPU; sits directly upstream of the ALU control stage.
- Sequences each instruction through fetch / decode / execute / memory / writeback.
- Drives datapath enables, mux selects and the 4-bit ALUOp consumed downstream.
- Waits on a memory ready handshake in the fetch and memory-access states.

Parameters:
- ALUOP_W, 4, width of ALUOp (fixed by the downstream ALU control stage).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- Op  in  6  instruction opcode, IR[31:26], valid from DECODE onward.
- MemReady  in  1  memory completed the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when ALU Zero=1 (beq).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  writeback data select: 0=ALUOut, 1=MDR.
- RegDst  out  1  destination register: 0=rt, 1=rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A operand: 0=PC, 1=regA.
- ALUSrcB  out  2  ALU B operand: 00=regB, 01=const 4, 10=ext(imm), 11=sext(imm)<<2.
- ExtZero  out  1  immediate extension: 1=zero-extend (andi/ori), 0=sign-extend.
- PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- ALUOp  out  ALUOP_W  ALU operation class, encoded below.
- IllegalOp  out  1  sticky flag; set on an unknown opcode.

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, andi=001100, ori=001101, j=000010.
- ALUOp codes: 0000 add, 0001 sub, 0010 use Funct, 0011 and, 0100 or. No other value is ever driven.
- Moore outputs decoded from the state register. Any output not listed for a state is 0 (ALUOp=0000).
- While rst=1, all outputs are forced to 0. On the first edge with rst=1: state<=FETCH, IllegalOp<=0.
- rst overrides everything, including mid-instruction and mid-memory-access; no partial write completes after reset.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0000, PCSource=00.
  - IRWrite and PCWrite are asserted only when MemReady=1 (Mealy qualification, FETCH only).
  - MemReady=0 -> hold in FETCH; MemReady=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0000 (branch target into ALUOut). Next state by Op:
  - lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQEX; addi -> ADDIEX; andi -> ANDIEX; ori -> ORIEX; j -> JEX.
  - Any other Op -> FETCH, with IllegalOp<=1 (sticky until rst).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtZero=0, ALUOp=0000. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady=1, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady=1, then -> FETCH. MemWrite stays high for the whole wait.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=0010 -> RTYPEWB.
- RTYPEWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=0001, PCWriteCond=1, PCSource=01 -> FETCH.
- ADDIEX / ANDIEX / ORIEX: ALUSrcA=1, ALUSrcB=10.
  - ADDIEX: ALUOp=0000, ExtZero=0. ANDIEX: ALUOp=0011, ExtZero=1. ORIEX: ALUOp=0100, ExtZero=1.
  - All three -> IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- JEX: PCWrite=1, PCSource=10 -> FETCH.
- Latency with MemReady tied 1: lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, j 3, illegal 2 cycles. Each memory wait cycle adds 1.
- Unreachable state encodings -> FETCH on the next edge, all outputs 0 while in them.

Decomposition:
- Package mips_ctrl_pkg: opcode constants, state encodings, ALUOp codes, ALUSrcB and PCSource select codes. The ALU control stage shares the ALUOp codes.
- One sub-module, mips_ctrl_outdec: combinational state-to-outputs decoder. Next-state logic and the IllegalOp register stay in the top.

Test Plan:
- rst=1 for 2 cycles mid-MEMWR -> all outputs 0, MemWrite=0 from the first reset cycle; after release, FETCH with MemRead=1, IorD=0, ALUSrcB=01.
- lw (Op=100011), MemReady=1 -> 5 cycles; MEMADR ALUOp=0000, ALUSrcB=10; MEMWB RegWrite=1, MemtoReg=1, RegDst=0.
- R-type, then andi (001100), then ori (001101) -> RTYPEEX ALUOp=0010; ANDIEX ALUOp=0011, ExtZero=1; ORIEX ALUOp=0100; each writes back and takes 4 cycles.
- beq (000100) -> BEQEX ALUOp=0001, PCWriteCond=1, PCSource=01, 3 cycles. j (000010) -> JEX PCWrite=1, PCSource=10.
- FETCH and MEMRD with MemReady low for 3 cycles -> state held; IRWrite/PCWrite=0 while waiting; single IRWrite pulse on the ready cycle; lw completes in 5+3+3 cycles.
- Op=111111 -> DECODE -> FETCH; IllegalOp=1 from the next cycle and stays set through the following valid instructions until rst.
